parallel_lane_packer: RTL and testbench
=======================================

# parallel_lane_packer

Producer-side front end for the parallel accumulator datapath. Accepts a scalar sample stream over a valid/ready handshake and packs every PAR_FACTOR consecutive samples into one parallel group. Each group is presented on a lane array with valid/ready and a lane-valid count. A stream marker flushes a partial group with zero-padded lanes, so downstream lane accumulators can be fed directly (m_valid && m_ready acts as their enable).

## Interface
- PAR_FACTOR, 4: lanes per group; legal range 2..16.
- DATA_WIDTH, 4: bits per sample/lane.
- CW, derived = $clog2(PAR_FACTOR+1): width of the lane count.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  input sample.
- s_valid  in  1  sample valid.
- s_last  in  1  final sample of a burst; qualified by s_valid.
- s_ready  out  1  packer can accept a sample this cycle.
- m_data  out  DATA_WIDTH x [PAR_FACTOR]  packed group; lane 0 holds the first sample.
- m_lanes  out  CW  number of valid lanes in m_data, 1..PAR_FACTOR.
- m_last  out  1  group closed by s_last.
- m_valid  out  1  group valid.
- m_ready  in  1  downstream accepts the group.

## Operation
- A sample is accepted when s_valid && s_ready. A group is transferred when m_valid && m_ready.
- Internal storage:
  - Gather register of PAR_FACTOR lanes, fill index idx (0..PAR_FACTOR-1), and last flag.
  - Output register holding m_data, m_lanes, m_last and m_valid.
- FSM states:
  - GATHER: s_ready=1.
    - An accepted sample writes lane[idx].
    - The group closes when idx==PAR_FACTOR-1 or s_last=1.
    - If the group does not close: idx++.
  - On close:
    - If the output slot is free (m_valid=0 or m_ready=1 this cycle): load the output register with the gathered lanes plus the incoming sample. m_lanes = idx+1. m_last = s_last. Lanes above idx are forced to 0. Then clear the gather register, set idx=0, stay in GATHER.
    - Otherwise: store the sample and the last flag into the gather register and go to PENDING.
  - PENDING: s_ready=0. On the first cycle with m_ready=1 (or m_valid=0), move the gather register into the output register, clear gather, set idx=0, return to GATHER.
- Output register clear: on a transfer with no new group loaded in the same cycle, m_valid goes to 0. m_data, m_lanes and m_last hold their last values, but are don't-care while m_valid=0.
- s_last on the first sample of a group produces a 1-lane group (m_lanes=1, lanes 1..PAR_FACTOR-1 = 0).
- s_data with s_valid=0 is ignored. s_last with s_valid=0 is ignored.
- There is no timeout flush. A partial group waits indefinitely for more samples or for s_last.
- Width rules:
  - Lanes carry samples unmodified.
  - m_lanes never reads 0 while m_valid=1.
  - idx never exceeds PAR_FACTOR-1.

## Timing
- Reset (synchronous, takes effect at the clock edge where rst=1): m_valid=0, m_data all lanes 0, m_lanes=0, m_last=0, idx=0, gather cleared, state GATHER. s_ready reads 1 from the first cycle after reset deasserts. While rst=1, s_ready=0.
- Latency: a group's m_valid rises the cycle after its closing sample is accepted, provided the output slot is free.
- Throughput: with m_ready held high, one sample is accepted every cycle with no bubbles. One group is emitted every PAR_FACTOR cycles.
- Backpressure:
  - m_ready=0 does not stall gathering until a second group closes; that close enters PENDING.
  - s_ready deasserts the cycle after entering PENDING.
  - s_ready reasserts the cycle after the pending group moves to the output register.
- AXI-style stability: while m_valid=1 and m_ready=0, m_data, m_lanes and m_last hold stable. m_valid does not drop without a transfer.
- Simultaneous events:
  - A group transfer and a new group load in the same cycle keep m_valid=1 with the new contents.
  - A transfer and a PENDING release in the same cycle behave the same way.
- Reset mid-operation discards the partial gather, the pending group and the output group. No partial output is emitted.

## Test plan
- Streaming: PAR_FACTOR=4, samples 1..8 with m_ready=1 and no s_last. Required: group {1,2,3,4} with m_lanes=4, m_last=0, then group {5,6,7,8}. Each m_valid pulse is 1 cycle after its 4th accept. s_ready stays 1 throughout.
- Partial flush: samples 9, A, B with s_last on B. Required: m_data={9,A,B,0}, m_lanes=3, m_last=1. The next sample lands in lane 0.
- Single-sample burst: sample 7 with s_last=1. Required: m_data={7,0,0,0}, m_lanes=1, m_last=1.
- Backpressure: m_ready=0, stream 1..12. Required:
  - First group is held stable on the output.
  - Second group closes and enters PENDING; s_ready=0 the following cycle, so samples 9..12 stall.
  - Raise m_ready for 1 cycle: {1,2,3,4} transfers, {5,6,7,8} is presented next cycle, and s_ready returns to 1.
- Reset mid-group: accept 3,4, assert rst for 1 cycle, then send 5,6,7,8. Required: m_valid=0 during and after reset. The only group emitted is {5,6,7,8} with m_lanes=4.
- Random valid/ready with random s_last, run against a scoreboard. Required: every sample appears exactly once, in order, in the correct lane. m_lanes matches each group's size, padding lanes are 0, and there are no stability violations.

Source files
------------

// File: rtl/parallel_lane_packer.sv
// Packs a scalar valid/ready sample stream into PAR_FACTOR-lane groups.
// A group closes when full or on s_last; short groups are zero-padded.
module parallel_lane_packer #(
  parameter int PAR_FACTOR = 4,
  parameter int DATA_WIDTH = 4,
  parameter int CW = $clog2(PAR_FACTOR + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [PAR_FACTOR*DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]                    m_lanes,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int IW = $clog2(PAR_FACTOR);
  localparam int GW = PAR_FACTOR * DATA_WIDTH;

  typedef enum logic {
    GATHER,
    PENDING
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] g_data;
  logic [GW-1:0] g_next;
  logic [IW-1:0] idx;
  logic          g_last;

  logic accept;
  logic full;
  logic close;
  logic slot_free;
  logic load_now;
  logic release_now;

  assign slot_free   = !m_valid || m_ready;
  assign accept      = s_valid && s_ready;
  assign full        = (idx == IW'(PAR_FACTOR - 1));
  assign close       = accept && (full || s_last);
  assign load_now    = close && slot_free;
  assign release_now = (state == PENDING) && slot_free;

  // Lanes above idx are forced to zero so short groups arrive padded.
  always_comb begin
    g_next = '0;
    for (int i = 0; i < PAR_FACTOR; i++) begin
      if (i == int'(idx))
        g_next[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
      else if (i < int'(idx))
        g_next[i*DATA_WIDTH +: DATA_WIDTH] =
          g_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= GATHER;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      GATHER:  if (close && !slot_free) state_nx = PENDING;
      PENDING: if (slot_free)           state_nx = GATHER;
      default: state_nx = GATHER;
    endcase
  end

  always_comb begin
    s_ready = !rst && (state == GATHER);
  end

  // In PENDING the gather register keeps the closed group and its idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_data <= '0;
      g_last <= 1'b0;
      idx    <= '0;
    end else if (load_now || release_now) begin
      g_data <= '0;
      g_last <= 1'b0;
      idx    <= '0;
    end else if (close) begin
      g_data <= g_next;
      g_last <= s_last;
    end else if (accept) begin
      g_data <= g_next;
      idx    <= idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_lanes <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (load_now) begin
      m_data  <= g_next;
      m_lanes <= CW'(idx) + CW'(1);
      m_last  <= s_last;
      m_valid <= 1'b1;
    end else if (release_now) begin
      m_data  <= g_data;
      m_lanes <= CW'(idx) + CW'(1);
      m_last  <= g_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parallel_lane_packer.sv
// Directed and scoreboarded random bench for parallel_lane_packer.
// Groups are captured on transfer and compared against hand-built values.
module tb_parallel_lane_packer;

  localparam int PF = 4;
  localparam int DW = 4;
  localparam int CW = $clog2(PF + 1);
  localparam int GW = PF * DW;

  typedef struct packed {
    logic [GW-1:0] d;
    logic [CW-1:0] n;
    logic          l;
  } grp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [GW-1:0] m_data;
  logic [CW-1:0] m_lanes;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  grp_t got_q[$];
  grp_t exp_q[$];
  logic rand_phase = 1'b0;

  parallel_lane_packer #(
    .PAR_FACTOR(PF),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_lanes(m_lanes),
    .m_last (m_last),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk)
    if (!rst && m_valid === 1'b1 && m_ready === 1'b1)
      got_q.push_back({m_data, m_lanes, m_last});

  logic          pv = 1'b0;
  logic [GW-1:0] pd;
  logic [CW-1:0] pn;
  logic          pl;

  // A stalled group must stay valid and unchanged.
  always @(posedge clk) begin
    if (pv) begin
      check("stable_valid", m_valid, 1);
      check("stable_data", m_data, pd);
      check("stable_lanes", m_lanes, pn);
      check("stable_last", m_last, pl);
    end
    pv <= m_valid && !m_ready && !rst;
    pd <= m_data;
    pn <= m_lanes;
    pl <= m_last;
  end

  initial forever begin
    @(negedge clk);
    if (rand_phase) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [DW-1:0] d, logic l, output int w);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    w = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      w++;
      if (w > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    sync();
  endtask

  task automatic expect_grp(string tag, logic [GW-1:0] d,
                            logic [CW-1:0] n, logic l);
    grp_t g;
    int   k = 0;
    while (got_q.size() == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    g = got_q.pop_front();
    check({tag, "_data"}, g.d, d);
    check({tag, "_lanes"}, g.n, n);
    check({tag, "_last"}, g.l, l);
  endtask

  initial begin
    int            w;
    int            cnt;
    logic [GW-1:0] cur;
    logic [DW-1:0] d;
    logic          l;
    grp_t          g;

    @(negedge clk);
    check("rst_sready", s_ready, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_lanes", m_lanes, 0);
    check("rst_last", m_last, 0);
    check("rst_sready_after", s_ready, 1);
    sync();

    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), 1'b0, w);
      check("stream_wait", w, 0);
      if (i == 4) begin
        check("stream_lat", m_valid, 1);
        check("stream_early", m_data, 16'h4321);
      end
      if (i == 5) check("stream_pulse", m_valid, 0);
      if (i == 8) check("stream_lat2", m_valid, 1);
    end
    s_valid = 1'b0;
    expect_grp("g1", 16'h4321, 4, 1'b0);
    expect_grp("g2", 16'h8765, 4, 1'b0);
    sync();

    send(4'h9, 1'b0, w);
    send(4'hA, 1'b0, w);
    send(4'hB, 1'b1, w);
    check("part_valid", m_valid, 1);
    check("part_data", m_data, 16'h0BA9);
    check("part_lanes", m_lanes, 3);
    check("part_last", m_last, 1);
    for (int i = 12; i <= 15; i++) send(DW'(i), 1'b0, w);
    s_valid = 1'b0;
    expect_grp("part", 16'h0BA9, 3, 1'b1);
    expect_grp("after", 16'hFEDC, 4, 1'b0);
    sync();

    send(4'h7, 1'b1, w);
    s_valid = 1'b0;
    check("one_data", m_data, 16'h0007);
    check("one_lanes", m_lanes, 1);
    expect_grp("one", 16'h0007, 1, 1'b1);
    sync();

    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), 1'b0, w);
      check("bp_wait", w, 0);
    end
    check("bp_pend_sready", s_ready, 0);
    check("bp_hold_valid", m_valid, 1);
    s_valid = 1'b1;
    s_data  = 4'h9;
    s_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", s_ready, 0);
      check("bp_hold", m_data, 16'h4321);
    end
    m_ready = 1'b1;
    sync();
    m_ready = 1'b0;
    check("bp_rel_valid", m_valid, 1);
    check("bp_rel_data", m_data, 16'h8765);
    check("bp_rel_lanes", m_lanes, 4);
    check("bp_rel_sready", s_ready, 1);
    for (int i = 9; i <= 12; i++) send(DW'(i), 1'b0, w);
    s_valid = 1'b0;
    m_ready = 1'b1;
    expect_grp("bp1", 16'h4321, 4, 1'b0);
    expect_grp("bp2", 16'h8765, 4, 1'b0);
    expect_grp("bp3", 16'hCBA9, 4, 1'b0);
    sync();

    send(4'h3, 1'b0, w);
    send(4'h4, 1'b0, w);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_sready", s_ready, 0);
    check("mrst_valid", m_valid, 0);
    sync();
    rst = 1'b0;
    check("mrst_valid_after", m_valid, 0);
    for (int i = 5; i <= 8; i++) send(DW'(i), 1'b0, w);
    s_valid = 1'b0;
    expect_grp("mrst", 16'h8765, 4, 1'b0);
    repeat (4) @(negedge clk);
    check("mrst_extra", got_q.size(), 0);
    sync();

    cur = '0;
    cnt = 0;
    rand_phase = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      d = DW'($urandom_range(0, 15));
      l = (k == 79) || ($urandom_range(0, 3) == 0);
      send(d, l, w);
      cur[cnt*DW +: DW] = d;
      cnt++;
      if (cnt == PF || l) begin
        exp_q.push_back({cur, CW'(cnt), l});
        cur = '0;
        cnt = 0;
      end
    end
    s_valid = 1'b0;
    rand_phase = 1'b0;
    @(negedge clk);
    #1;
    m_ready = 1'b1;
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      expect_grp("rnd", g.d, g.n, g.l);
    end
    repeat (4) @(negedge clk);
    check("rnd_extra", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
